// File: rtl/alu_defs.sv
// Shared definitions for the ALU decode stage: control-bit indices, LA32R opcodes
// and the decoded bundle carried by the pipeline register.
package alu_defs;

    localparam int XLEN  = 32;
    localparam int OP_W  = 14;
    localparam int RF_AW = 5;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_IMM = 4'd1;
    localparam logic [3:0] ALU_OP_OR  = 4'd2;
    localparam logic [3:0] ALU_OP_SUB = 4'd3;
    localparam logic [3:0] ALU_OP_XOR = 4'd4;
    localparam logic [3:0] ALU_OP_SRA = 4'd5;
    localparam logic [3:0] ALU_OP_AND = 4'd6;
    localparam logic [3:0] ALU_OP_SLL = 4'd7;
    localparam logic [3:0] ALU_OP_SRL = 4'd8;

    // Register-register and shift-immediate opcodes live in inst[31:15].
    localparam logic [16:0] OPC_ADD_W  = 17'h00020;
    localparam logic [16:0] OPC_SUB_W  = 17'h00022;
    localparam logic [16:0] OPC_AND    = 17'h00029;
    localparam logic [16:0] OPC_OR     = 17'h0002A;
    localparam logic [16:0] OPC_XOR    = 17'h0002B;
    localparam logic [16:0] OPC_SLL_W  = 17'h0002E;
    localparam logic [16:0] OPC_SRL_W  = 17'h0002F;
    localparam logic [16:0] OPC_SRA_W  = 17'h00030;
    localparam logic [16:0] OPC_SLLI_W = 17'h00081;
    localparam logic [16:0] OPC_SRLI_W = 17'h00089;
    localparam logic [16:0] OPC_SRAI_W = 17'h00091;
    localparam logic [9:0]  OPC_ADDI_W  = 10'h00A;
    localparam logic [6:0]  OPC_LU12I_W = 7'b0001010;

    typedef struct packed {
        logic [OP_W-1:0]  alu_op;
        logic [XLEN-1:0]  src1;
        logic [XLEN-1:0]  src2;
        logic [RF_AW-1:0] rd;
        logic             rf_we;
        logic             illegal;
    } decoded_t;

    function automatic logic [OP_W-1:0] alu_onehot(input logic [3:0] idx);
        alu_onehot = {{(OP_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_inst_decoder.sv
// Pure-combinational LA32R instruction + operand to decoded-bundle mapping.
module alu_inst_decoder
    import alu_defs::*;
(
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rj_data,
    input  logic [XLEN-1:0] rk_data,
    output decoded_t        dec
);

    logic [OP_W-1:0] op_s;
    logic [XLEN-1:0] src1_s;
    logic [XLEN-1:0] src2_s;
    logic            legal_s;
    logic [XLEN-1:0] rk_shamt_s;
    logic [XLEN-1:0] imm_shamt_s;

    // Register shifts only ever see a 0..31 amount.
    assign rk_shamt_s  = {{(XLEN-5){1'b0}}, rk_data[4:0]};
    assign imm_shamt_s = {{(XLEN-5){1'b0}}, inst[14:10]};

    // Opcode match and operand selection; anything unmatched is illegal with zeroed operands.
    always_comb begin
        op_s    = {OP_W{1'b0}};
        src1_s  = {XLEN{1'b0}};
        src2_s  = {XLEN{1'b0}};
        legal_s = 1'b1;
        case (inst[31:15])
            OPC_ADD_W:  begin op_s = alu_onehot(ALU_OP_ADD); src1_s = rj_data; src2_s = rk_data;     end
            OPC_SUB_W:  begin op_s = alu_onehot(ALU_OP_SUB); src1_s = rj_data; src2_s = rk_data;     end
            OPC_AND:    begin op_s = alu_onehot(ALU_OP_AND); src1_s = rj_data; src2_s = rk_data;     end
            OPC_OR:     begin op_s = alu_onehot(ALU_OP_OR);  src1_s = rj_data; src2_s = rk_data;     end
            OPC_XOR:    begin op_s = alu_onehot(ALU_OP_XOR); src1_s = rj_data; src2_s = rk_data;     end
            OPC_SLL_W:  begin op_s = alu_onehot(ALU_OP_SLL); src1_s = rj_data; src2_s = rk_shamt_s;  end
            OPC_SRL_W:  begin op_s = alu_onehot(ALU_OP_SRL); src1_s = rj_data; src2_s = rk_shamt_s;  end
            OPC_SRA_W:  begin op_s = alu_onehot(ALU_OP_SRA); src1_s = rj_data; src2_s = rk_shamt_s;  end
            OPC_SLLI_W: begin op_s = alu_onehot(ALU_OP_SLL); src1_s = rj_data; src2_s = imm_shamt_s; end
            OPC_SRLI_W: begin op_s = alu_onehot(ALU_OP_SRL); src1_s = rj_data; src2_s = imm_shamt_s; end
            OPC_SRAI_W: begin op_s = alu_onehot(ALU_OP_SRA); src1_s = rj_data; src2_s = imm_shamt_s; end
            default: begin
                // Wider-immediate formats cannot alias the 17-bit opcodes above.
                if (inst[31:22] == OPC_ADDI_W) begin
                    op_s   = alu_onehot(ALU_OP_ADD);
                    src1_s = rj_data;
                    src2_s = {{(XLEN-12){inst[21]}}, inst[21:10]};
                end else if (inst[31:25] == OPC_LU12I_W) begin
                    op_s   = alu_onehot(ALU_OP_IMM);
                    src1_s = {inst[24:5], 12'h000};
                end else begin
                    legal_s = 1'b0;
                end
            end
        endcase
    end

    assign dec = '{
        alu_op:  op_s,
        src1:    src1_s,
        src2:    src2_s,
        rd:      inst[4:0],
        rf_we:   legal_s && (inst[4:0] != 5'd0),
        illegal: !legal_s
    };

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage feeding the execute ALU through a single-entry valid/ready register.
// Optional writeback forwarding into the operand path: define ALU_DECODE_WB_FWD_EN.
module alu_decode_stage
    import alu_defs::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic [RF_AW-1:0] rf_raddr1,
    output logic [RF_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
`ifdef ALU_DECODE_WB_FWD_EN
    input  logic             wb_we,
    input  logic [RF_AW-1:0] wb_waddr,
    input  logic [XLEN-1:0]  wb_wdata,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_alu_op,
    output logic [XLEN-1:0]  out_alu_src1,
    output logic [XLEN-1:0]  out_alu_src2,
    output logic [RF_AW-1:0] out_rd,
    output logic             out_rf_we,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal
);

    logic            out_valid_r;
    decoded_t        dec_s;
    decoded_t        dec_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] rj_data_s;
    logic [XLEN-1:0] rk_data_s;
    logic            load_s;

    assign rf_raddr1 = in_inst[9:5];
    assign rf_raddr2 = in_inst[14:10];

`ifdef ALU_DECODE_WB_FWD_EN
    // Bypass a same-cycle writeback that the register file would not yet return.
    assign rj_data_s = (wb_we && (wb_waddr != 5'd0) && (wb_waddr == rf_raddr1)) ? wb_wdata : rf_rdata1;
    assign rk_data_s = (wb_we && (wb_waddr != 5'd0) && (wb_waddr == rf_raddr2)) ? wb_wdata : rf_rdata2;
`else
    assign rj_data_s = rf_rdata1;
    assign rk_data_s = rf_rdata2;
`endif

    alu_inst_decoder u_decoder (
        .inst    (in_inst),
        .rj_data (rj_data_s),
        .rk_data (rk_data_s),
        .dec     (dec_s)
    );

    assign in_ready = !out_valid_r || out_ready;
    assign load_s   = in_valid && in_ready && !flush;

    // Pipeline register: flush wins over a load, a load wins over a plain consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            dec_r       <= '0;
            pc_r        <= {XLEN{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            dec_r       <= dec_s;
            pc_r        <= in_pc;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_alu_op   = dec_r.alu_op;
    assign out_alu_src1 = dec_r.src1;
    assign out_alu_src2 = dec_r.src2;
    assign out_rd       = dec_r.rd;
    assign out_rf_we    = dec_r.rf_we;
    assign out_illegal  = dec_r.illegal;
    assign out_pc       = pc_r;

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode pipeline stage that drives the execute-stage ALU.
- Accepts a 32-bit LA32R instruction from fetch, reads two register-file operands, and encodes the one-hot 14-bit ALU control vector.
- Registers the ALU control vector, both ALU source operands and the writeback destination into a single-entry pipeline register.
- Uses a valid/ready handshake on both sides. It is the producer end of the ALU op/operand interface.

Parameters:
- XLEN, 32, datapath width.
- OP_W, 14, ALU control vector width.
- RF_AW, 5, register address width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of the held instruction (branch/exception redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  32  instruction PC.
- rf_raddr1  output  5  combinational read address = in_inst[9:5] (rj).
- rf_raddr2  output  5  combinational read address = in_inst[14:10] (rk).
- rf_rdata1  input  32  read data for rf_raddr1 (same cycle).
- rf_rdata2  input  32  read data for rf_raddr2 (same cycle).
- out_valid  output  1  held entry valid for execute.
- out_ready  input  1  execute consumes the held entry.
- out_alu_op  output  14  one-hot ALU control.
- out_alu_src1  output  32  ALU operand 1.
- out_alu_src2  output  32  ALU operand 2.
- out_rd  output  5  destination register.
- out_rf_we  output  1  writeback enable.
- out_pc  output  32  PC of the held entry.
- out_illegal  output  1  held entry was not a supported instruction.

Behaviour:
- ALU control bit map:
  - 0 add, 1 imm (pass src1), 2 or, 3 sub, 4 xor, 5 sra, 6 and, 7 sll, 8 srl.
  - Bits 13:9 reserved and always 0.
  - Exactly one bit is set for any legal instruction; all zero for an illegal one.
- Register-register instructions (inst[31:15]); src1=rj data, src2=rk data:
  - add.w 0x00020 -> bit0.
  - sub.w 0x00022 -> bit3.
  - and 0x00029 -> bit6.
  - or 0x0002A -> bit2.
  - xor 0x0002B -> bit4.
  - sll.w 0x0002E -> bit7.
  - srl.w 0x0002F -> bit8.
  - sra.w 0x00030 -> bit5.
- Shift-immediate instructions (inst[31:15]); src1=rj data, src2={27'b0, inst[14:10]}:
  - slli.w 0x00081 -> bit7.
  - srli.w 0x00089 -> bit8.
  - srai.w 0x00091 -> bit5.
- addi.w (inst[31:22]=0x00A) -> bit0; src1=rj data, src2=sign-extended inst[21:10].
- lu12i.w (inst[31:25]=7'b0001010) -> bit1; src1={inst[24:5],12'b0}, src2=0.
- All register shifts force src2={27'b0, rk_data[4:0]}, so the shift amount is always 0..31.
- Destination and writeback enable:
  - out_rd=inst[4:0].
  - out_rf_we=1 for a legal instruction with rd!=0; 0 for rd=0 or illegal.
- Illegal instruction: out_illegal=1, alu_op=0, src1=src2=0, rf_we=0. It is still handed downstream so execute can raise an exception.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational; no dependency on in_valid).
  - Load occurs on in_valid & in_ready: all out_* fields are registered.
  - Latency: 1 cycle from accept to out_valid.
  - While out_valid & !out_ready, every out_* field holds stable.
- out_valid update, in priority order:
  - flush -> out_valid=0 and nothing is accepted that cycle; in_ready is still driven per formula, but the load is suppressed.
  - else accept -> out_valid=1.
  - else out_ready -> out_valid=0.
  - Simultaneous consume and accept gives back-to-back throughput of 1 instruction per cycle.
- Reset (rst_n=0, asynchronous): out_valid=0, out_alu_op=0, src1=src2=0, out_rd=0, out_rf_we=0, out_pc=0, out_illegal=0.
- Reset asserted mid-stall discards the held entry immediately.

Optional Feature:
- Macro ALU_DECODE_WB_FWD_EN adds ports wb_we (1), wb_waddr (5) and wb_wdata (32).
- When defined: if wb_we & wb_waddr!=0 & wb_waddr==rf_raddrN, wb_wdata replaces rf_rdataN before operand selection. This applies to both ports independently.
- When undefined: no extra ports; operands come only from rf_rdata1/2.

Decomposition:
- Shared package alu_defs holds:
  - ALU_OP_* bit-index constants and OP_W.
  - Opcode constants for every supported instruction.
  - A decoded-bundle typedef {alu_op, src1, src2, rd, rf_we, illegal}.
- One natural sub-module, alu_inst_decoder: pure-combinational instruction/operand to bundle mapping.
- The stage module owns only the handshake, the pipeline register and the optional forwarding mux.

Test Plan:
- add.w r3,r1,r2 (0x00100823), r1=5, r2=7, out_ready=1 -> next cycle out_alu_op=0x0001, src1=5, src2=7, rd=3, rf_we=1.
- addi.w r4,r1,-1 (0x02BFFC24), r1=5 -> alu_op=0x0001, src2=0xFFFFFFFF, rd=4; lu12i.w r5,0x12345 (0x142468A5) -> alu_op=0x0002, src1=0x12345000.
- sra.w with rk data 0xFFFFFF23 -> alu_op=0x0020, src2=0x00000003; word 0xFFFFFFFF -> out_illegal=1, alu_op=0, rf_we=0.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; out_ready=1 -> next queued instruction appears the following cycle with no bubble.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the presented instruction is not loaded.
- rst_n dropped asynchronously mid-stall -> all outputs 0 without a clock edge. With ALU_DECODE_WB_FWD_EN: wb_we=1, wb_waddr=1, wb_wdata=0xAA on add.w r3,r1,r2 -> src1=0xAA.
